// File: rtl/pool2x2_sequencer.sv
// pool2x2_sequencer: start-triggered 2x2/stride-2 signed max-pool over a stored feature map.
// Window j result 4j+RD_LAT+5 cycles after iStart, oDone at 4N+RD_LAT+2; no backpressure, one read per cycle.
module pool2x2_sequencer #(
  parameter  int IMG_W   = 8,
  parameter  int IMG_H   = 8,
  parameter  int DATA_W  = 16,
  parameter  int RD_LAT  = 3,
  localparam int ADDR_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int OADDR_W = ((IMG_W / 2) * (IMG_H / 2) > 1) ? $clog2((IMG_W / 2) * (IMG_H / 2)) : 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               iStart,
  output logic               oRdEn,
  output logic [ADDR_W-1:0]  oRdAddr,
  input  logic [DATA_W-1:0]  iRdData,
  output logic               oPoolValid,
  output logic [DATA_W-1:0]  oPoolData,
  output logic [OADDR_W-1:0] oPoolAddr,
  output logic               oBusy,
  output logic               oDone
);

  localparam int OCOLS  = IMG_W / 2;
  localparam int OROWS  = IMG_H / 2;
  localparam int NWIN   = OCOLS * OROWS;
  localparam int OCOL_W = (OCOLS > 1) ? $clog2(OCOLS) : 1;
  localparam int OROW_W = (OROWS > 1) ? $clog2(OROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic               vld;
    logic               first;
    logic               last;
    logic [OADDR_W-1:0] idx;
  } tag_t;

  state_t                   r_state;
  logic [1:0]               r_sub;
  logic [OCOL_W-1:0]        r_ocol;
  logic [OROW_W-1:0]        r_orow;
  logic [OADDR_W-1:0]       r_widx;
  tag_t                     r_rd_tag;
  logic [ADDR_W-1:0]        r_rd_addr;
  tag_t                     r_tag [RD_LAT];
  logic signed [DATA_W-1:0] r_acc;
  logic                     r_pool_vld;
  logic [DATA_W-1:0]        r_pool_dat;
  logic [OADDR_W-1:0]       r_pool_addr;
  logic                     r_busy;
  logic                     r_done;

  logic [ADDR_W-1:0]        w_rd_addr;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_final_read;
  logic [1:0]               w_sub_n;
  logic [OCOL_W-1:0]        w_ocol_n;
  logic [OROW_W-1:0]        w_orow_n;
  logic [OADDR_W-1:0]       w_widx_n;
  tag_t                     w_ret;
  logic [DATA_W-1:0]        w_max;
  logic                     w_final_pool;

  // Counters name the read about to be issued; sub walks TL, TR, BL, BR of the window.
  always_comb begin
    w_rd_addr    = ADDR_W'((2 * int'(r_orow) + int'(r_sub[1])) * IMG_W
                           + 2 * int'(r_ocol) + int'(r_sub[0]));
    w_last_col   = (r_ocol == OCOL_W'(OCOLS - 1));
    w_last_row   = (r_orow == OROW_W'(OROWS - 1));
    w_final_read = (r_sub == 2'd3) && w_last_col && w_last_row;
    w_sub_n      = r_sub + 2'd1;
    w_ocol_n     = r_ocol;
    w_orow_n     = r_orow;
    w_widx_n     = r_widx;
    if (r_sub == 2'd3) begin
      w_widx_n = w_final_read ? '0 : r_widx + OADDR_W'(1);
      if (w_last_col) begin
        w_ocol_n = '0;
        w_orow_n = w_last_row ? '0 : r_orow + OROW_W'(1);
      end else begin
        w_ocol_n = r_ocol + OCOL_W'(1);
      end
    end
  end

  assign w_ret        = r_tag[RD_LAT-1];
  assign w_max        = ($signed(iRdData) > r_acc) ? iRdData : r_acc;
  assign w_final_pool = r_pool_vld && (r_pool_addr == OADDR_W'(NWIN - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_sub       <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_widx      <= '0;
      r_rd_tag    <= '0;
      r_rd_addr   <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      r_acc       <= '0;
      r_pool_vld  <= 1'b0;
      r_pool_dat  <= '0;
      r_pool_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Tag of the read on the port enters the delay line, lining up with its data RD_LAT later.
      r_tag[0] <= r_rd_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];

      if (w_ret.vld) begin
        r_acc <= w_ret.first ? $signed(iRdData) : $signed(w_max);
      end
      r_pool_vld <= w_ret.vld && w_ret.last;
      if (w_ret.vld && w_ret.last) begin
        r_pool_dat  <= w_max;
        r_pool_addr <= w_ret.idx;
      end

      r_rd_tag.vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_state        <= RUN;
            r_busy         <= 1'b1;
            r_rd_tag.vld   <= 1'b1;
            r_rd_tag.first <= 1'b1;
            r_rd_tag.last  <= 1'b0;
            r_rd_tag.idx   <= '0;
            r_rd_addr      <= '0;
            r_sub          <= 2'd1;
            r_ocol         <= '0;
            r_orow         <= '0;
            r_widx         <= '0;
          end
        end
        RUN: begin
          r_rd_tag.vld   <= 1'b1;
          r_rd_tag.first <= (r_sub == 2'd0);
          r_rd_tag.last  <= (r_sub == 2'd3);
          r_rd_tag.idx   <= r_widx;
          r_rd_addr      <= w_rd_addr;
          r_sub          <= w_sub_n;
          r_ocol         <= w_ocol_n;
          r_orow         <= w_orow_n;
          r_widx         <= w_widx_n;
          if (w_final_read) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_final_pool) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oRdEn      = r_rd_tag.vld;
  assign oRdAddr    = r_rd_addr;
  assign oPoolValid = r_pool_vld;
  assign oPoolData  = r_pool_dat;
  assign oPoolAddr  = r_pool_addr;
  assign oBusy      = r_busy;
  assign oDone      = r_done;

endmodule

// File: tb/tb_pool2x2_sequencer.sv
// Bench for pool2x2_sequencer: three 4x4 instances (RD_LAT 3, 1, 6) each run the same directed frame plan,
// with expected reads, pooled results, done and busy length queued at stimulus time and checked by a monitor.
module tb_pool2x2_sequencer;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] dat;
  } pexp_t;

  typedef struct {
    int cyc;
    int addr;
  } rexp_t;

  localparam int BIG = 1 << 30;

  bit clk = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_fin = 0;

  int          rd_order [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  logic [15:0] exp_ramp [4]  = '{16'd5, 16'd7, 16'd13, 16'd15};
  logic [15:0] exp_sgn  [4]  = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFB};
  logic [15:0] sgn_mem  [16] = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h8000,
                                 16'hFFF9, 16'hFFFE, 16'h8000, 16'h8000,
                                 16'h0064, 16'hFF38, 16'hFFFB, 16'hFFFB,
                                 16'h7FFF, 16'h7FFE, 16'hFFFA, 16'hFFFB};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Returns 1 time unit after clock edge number t.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 3 : ((gi == 1) ? 1 : 6);

    logic        rst_n;
    logic        start;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_dat;
    logic        pv;
    logic [15:0] pdat;
    logic [1:0]  paddr;
    logic        busy;
    logic        done;
    logic [15:0] mem  [16];
    logic [15:0] pipe [LAT];
    pexp_t       pq [$];
    rexp_t       rq [$];
    int          dq [$];
    int          bq [$];

    pool2x2_sequencer #(
      .IMG_W (4),
      .IMG_H (4),
      .DATA_W(16),
      .RD_LAT(LAT)
    ) u_dut (
      .aclk      (clk),
      .aresetn   (rst_n),
      .iStart    (start),
      .oRdEn     (rd_en),
      .oRdAddr   (rd_addr),
      .iRdData   (rd_dat),
      .oPoolValid(pv),
      .oPoolData (pdat),
      .oPoolAddr (paddr),
      .oBusy     (busy),
      .oDone     (done)
    );

    // Fixed-latency memory; idle slots carry junk so stray captures show up.
    always @(posedge clk) begin
      pipe[0] <= rd_en ? mem[rd_addr] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_dat = pipe[LAT-1];

    function automatic string nm(input string s);
      return $sformatf("L%0d %s", LAT, s);
    endfunction

    // Queue everything a frame started in cycle t0 should show before cycle cut.
    task automatic push_frame(input int t0, input bit sgn, input int cut);
      rexp_t r;
      pexp_t p;
      int    bend;
      for (int k = 0; k < 16; k++) begin
        r.cyc  = t0 + 1 + k;
        r.addr = rd_order[k];
        if (r.cyc < cut) rq.push_back(r);
      end
      for (int j = 0; j < 4; j++) begin
        p.cyc  = t0 + 4 * j + LAT + 5;
        p.addr = j;
        p.dat  = sgn ? exp_sgn[j] : exp_ramp[j];
        if (p.cyc < cut) pq.push_back(p);
      end
      if (t0 + 16 + LAT + 2 < cut) dq.push_back(t0 + 16 + LAT + 2);
      bend = (cut < t0 + 16 + LAT + 3) ? cut : t0 + 16 + LAT + 3;
      bq.push_back(bend - (t0 + 1));
    endtask

    task automatic pulse(input int t);
      wait_until(t);
      start = 1'b1;
      wait_until(t + 1);
      start = 1'b0;
    endtask

    initial begin : stim
      int td;
      rst_n = 1'b0;
      start = 1'b0;
      for (int a = 0; a < 16; a++) mem[a] = 16'(a);
      wait_until(1);
      @(negedge clk);
      check(nm("reset outputs"), {rd_en, rd_addr, pv, pdat, paddr, busy, done}, 32'd0);
      wait_until(3);
      rst_n = 1'b1;

      // Ramp frame, with ignored starts mid-frame and in the oDone cycle.
      td = 10 + 16 + LAT + 2;
      push_frame(10, 1'b0, BIG);
      pulse(10);
      pulse(15);
      pulse(td);

      // Back-to-back frames: second start in the cycle after oDone.
      td = 60 + 16 + LAT + 2;
      push_frame(60, 1'b0, BIG);
      pulse(60);
      push_frame(td + 1, 1'b0, BIG);
      pulse(td + 1);

      wait_until(140);
      for (int a = 0; a < 16; a++) mem[a] = sgn_mem[a];
      push_frame(150, 1'b1, BIG);
      pulse(150);

      // Reset ten cycles into a ramp frame, then a fresh frame.
      wait_until(190);
      for (int a = 0; a < 16; a++) mem[a] = 16'(a);
      push_frame(200, 1'b0, 210);
      pulse(200);
      wait_until(210);
      rst_n = 1'b0;
      @(negedge clk);
      check(nm("mid-frame reset outputs"), {rd_en, rd_addr, pv, pdat, paddr, busy, done}, 32'd0);
      wait_until(212);
      rst_n = 1'b1;
      push_frame(230, 1'b0, BIG);
      pulse(230);

      wait_until(280);
      check(nm("pending reads"), rq.size(), 0);
      check(nm("pending pools"), pq.size(), 0);
      check(nm("pending dones"), dq.size(), 0);
      check(nm("pending busy"), bq.size(), 0);
      n_fin++;
    end

    initial begin : mon
      rexp_t r;
      pexp_t p;
      int    blen;
      blen = 0;
      forever begin
        @(negedge clk);
        if (rd_en) begin
          if (rq.size() == 0) check(nm("extra read"), rd_en, 1'b0);
          else begin
            r = rq.pop_front();
            check(nm("read cycle"), cyc, r.cyc);
            check(nm("read addr"), rd_addr, r.addr);
          end
        end
        if (pv) begin
          if (pq.size() == 0) check(nm("extra pool"), pv, 1'b0);
          else begin
            p = pq.pop_front();
            check(nm("pool cycle"), cyc, p.cyc);
            check(nm("pool addr"), paddr, p.addr);
            check(nm("pool data"), pdat, p.dat);
          end
        end
        if (done) begin
          if (dq.size() == 0) check(nm("extra done"), done, 1'b0);
          else check(nm("done cycle"), cyc, dq.pop_front());
        end
        if (busy) blen++;
        else if (blen > 0) begin
          if (bq.size() == 0) check(nm("extra busy"), blen, 0);
          else check(nm("busy length"), blen, bq.pop_front());
          blen = 0;
        end
      end
    end
  end

  initial begin : summary
    while (n_fin < 3 && cyc < 1000) @(posedge clk);
    if (n_fin < 3) check("finish timeout", n_fin, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool2x2_sequencer.md
# pool2x2_sequencer

Start-triggered 2x2 / stride-2 max-pooling engine for the second pooling stage. It consumes the single-cycle start strobe produced by the start-delay pipeline. It then walks a stored IMG_W x IMG_H feature map through a fixed-latency read port and emits one pooled value per window. It finishes the frame with a single-cycle done strobe that the next stage's start delay line can take directly.

## Interface
- IMG_W, 8: feature-map width in pixels; even, >= 2.
- IMG_H, 8: feature-map height in pixels; even, >= 2.
- DATA_W, 16: pixel width, signed two's complement.
- RD_LAT, 3: read latency of the feature-map memory in cycles; >= 1.
- ADDR_W, derived: clog2(IMG_W*IMG_H), minimum 1.
- OADDR_W, derived: clog2((IMG_W/2)*(IMG_H/2)), minimum 1.
- aclk, input, 1: clock; all logic rising-edge.
- aresetn, input, 1: reset; asynchronous, active-low.
- iStart, input, 1: start strobe; sampled only in IDLE.
- oRdEn, output, 1: memory read enable.
- oRdAddr, output, ADDR_W: memory read address; row*IMG_W + col.
- iRdData, input, DATA_W: read data; valid exactly RD_LAT cycles after the matching oRdEn cycle.
- oPoolValid, output, 1: one-cycle strobe qualifying oPoolData and oPoolAddr.
- oPoolData, output, DATA_W: signed max of the 4 window pixels.
- oPoolAddr, output, OADDR_W: output index; orow*(IMG_W/2) + ocol.
- oBusy, output, 1: high from the first read cycle through the oDone cycle inclusive.
- oDone, output, 1: one-cycle end-of-frame strobe.

## Operation
- FSM states:
  - IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when iStart = 1.
  - RUN -> DRAIN after the final read is issued.
  - DRAIN -> DONE when the final window's result has been registered.
  - DONE -> IDLE unconditionally after one cycle.
- Read order in RUN: one read per cycle, no gaps.
  - Windows in raster order: orow 0..IMG_H/2-1 (outer), ocol 0..IMG_W/2-1 (inner).
  - Within each window, in order: (2orow,2ocol), (2orow,2ocol+1), (2orow+1,2ocol), (2orow+1,2ocol+1).
- Tag pipeline: an RD_LAT-deep shift register carries {valid, first, last, out index} alongside each read.
- Accumulator, on a returning tag:
  - first: acc <= iRdData.
  - otherwise: acc <= signed max(acc, iRdData).
  - last: oPoolData <= signed max(acc, iRdData), oPoolAddr <= tag index, oPoolValid <= 1 for one cycle.
- Comparison is signed at DATA_W bits; equal values keep acc. No width growth.
- iStart outside IDLE is ignored. It is not queued, including during DONE.
- Total windows N = (IMG_W/2)*(IMG_H/2); total reads 4N. Counters wrap at frame end and clear on the IDLE -> RUN transition.
- Reset values: all outputs 0; state IDLE; tag pipeline and accumulator cleared.
- Asserting aresetn low mid-frame aborts immediately:
  - No oPoolValid or oDone is produced for the aborted frame.
  - In-flight tags are discarded.
  - The next iStart after release starts a fresh frame at address 0.

## Timing
- iStart high at edge t0 (FSM in IDLE):
  - First oRdEn/oRdAddr = 0 registered at t0+1.
  - Read k is issued at cycle t0+1+k.
- Read k data arrives at t0+1+k+RD_LAT.
- Window j result: oPoolValid at cycle t0+4j+RD_LAT+5.
- oDone at t0+4N+RD_LAT+2, one cycle after the final oPoolValid. oBusy falls the following cycle.
- Earliest accepted restart: iStart in the cycle after oDone.
- oRdEn and oRdAddr are registered, with no combinational path from iStart.
- oRdAddr holds its last value when oRdEn = 0.

## Test plan
- Ramp frame:
  - Setup: IMG_W=4, IMG_H=4, RD_LAT=3, mem[a]=a, single iStart.
  - Required: oPoolData 5,7,13,15 at oPoolAddr 0..3, spaced 4 cycles, first at t0+8.
  - Required: oDone at t0+21, oBusy high for exactly 21 cycles.
- Signed max:
  - Setup: window values -3, -1, -7, -2.
  - Required: oPoolData = -1; all-equal window 0x8000 x4 -> 0x8000.
- Start while busy:
  - Stimulus: pulse iStart at t0+5 and again in the oDone cycle.
  - Required: no extra reads, exactly 4 outputs, one oDone.
- Back-to-back frames:
  - Stimulus: iStart in the cycle after oDone.
  - Required: second frame identical to the first, starting again at address 0.
- Reset mid-frame:
  - Stimulus: aresetn low at t0+10 for 2 cycles.
  - Required: all outputs 0 immediately, no oPoolValid/oDone afterwards.
  - Required: a fresh iStart reproduces the ramp results exactly.
- Latency sweep:
  - Setup: RD_LAT = 1 and 6 with the ramp frame.
  - Required: results unchanged; oDone at t0+4N+RD_LAT+2.
